// File: rtl/vga_timing_gen_if.sv
// Raster output bundle of vga_timing_gen plus the pixel clock-enable.
// frame_cnt and FCW exist only when VGA_TIMER_FRAME_CNT_EN is defined.
interface vga_timing_gen_if #(
   parameter int unsigned CW  = 11
`ifdef VGA_TIMER_FRAME_CNT_EN
   , parameter int unsigned FCW = 8
`endif
);
   logic          pix_en;
   logic          hsync;
   logic          vsync;
   logic          vga_on;
   logic [CW-1:0] Pixel_X;
   logic [CW-1:0] Pixel_Y;
   logic          line_start;
   logic          frame_start;
`ifdef VGA_TIMER_FRAME_CNT_EN
   logic [FCW-1:0] frame_cnt;
`endif

   modport master (
      input  pix_en,
      output hsync, vsync, vga_on, Pixel_X, Pixel_Y, line_start, frame_start
`ifdef VGA_TIMER_FRAME_CNT_EN
      , output frame_cnt
`endif
   );

   modport slave (
      output pix_en,
      input  hsync, vsync, vga_on, Pixel_X, Pixel_Y, line_start, frame_start
`ifdef VGA_TIMER_FRAME_CNT_EN
      , input frame_cnt
`endif
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with registered, mutually aligned outputs.
// Optional frame counter enabled by defining VGA_TIMER_FRAME_CNT_EN.
module vga_timing_gen #(
   parameter int unsigned CW       = 11,
   parameter int unsigned H_ACTIVE = 800,
   parameter int unsigned H_FP     = 56,
   parameter int unsigned H_SYNC   = 120,
   parameter int unsigned H_BP     = 64,
   parameter int unsigned V_ACTIVE = 600,
   parameter int unsigned V_FP     = 37,
   parameter int unsigned V_SYNC   = 6,
   parameter int unsigned V_BP     = 23,
   parameter bit          HS_POL   = 1'b1,
   parameter bit          VS_POL   = 1'b1
`ifdef VGA_TIMER_FRAME_CNT_EN
   , parameter int unsigned FCW    = 8
`endif
) (
   input  logic              mclk,
   input  logic              clr,
   vga_timing_gen_if.master  vif
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
   localparam int unsigned HS_END  = HS_BEG + H_SYNC;
   localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
   localparam int unsigned VS_END  = VS_BEG + V_SYNC;

   logic [CW-1:0] h_cnt_q, h_cnt_d;
   logic [CW-1:0] v_cnt_q, v_cnt_d;
   logic [CW-1:0] pixel_x_q, pixel_x_d;
   logic [CW-1:0] pixel_y_q, pixel_y_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          vga_on_q, vga_on_d;
   logic          line_start_q, line_start_d;
   logic          frame_start_q, frame_start_d;
   logic          h_last, v_last, active, hs_act, vs_act;
`ifdef VGA_TIMER_FRAME_CNT_EN
   logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
`endif

   // Decode the current (pre-increment) position and advance the raster on enabled edges.
   always_comb begin
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      pixel_x_d     = pixel_x_q;
      pixel_y_d     = pixel_y_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      vga_on_d      = vga_on_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
`ifdef VGA_TIMER_FRAME_CNT_EN
      frame_cnt_d   = frame_cnt_q;
`endif
      h_last = (h_cnt_q == CW'(H_TOTAL - 1));
      v_last = (v_cnt_q == CW'(V_TOTAL - 1));
      active = (h_cnt_q < CW'(H_ACTIVE)) && (v_cnt_q < CW'(V_ACTIVE));
      hs_act = (h_cnt_q >= CW'(HS_BEG)) && (h_cnt_q < CW'(HS_END));
      vs_act = (v_cnt_q >= CW'(VS_BEG)) && (v_cnt_q < CW'(VS_END));

      if (vif.pix_en) begin
         h_cnt_d = h_last ? '0 : h_cnt_q + CW'(1);
         if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + CW'(1);
         end
         vga_on_d      = active;
         pixel_x_d     = active ? h_cnt_q : '0;
         pixel_y_d     = active ? v_cnt_q : '0;
         hsync_d       = hs_act ? HS_POL : ~HS_POL;
         vsync_d       = vs_act ? VS_POL : ~VS_POL;
         line_start_d  = (h_cnt_q == '0);
         frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
`ifdef VGA_TIMER_FRAME_CNT_EN
         if ((h_cnt_q == '0) && (v_cnt_q == '0)) begin
            frame_cnt_d = frame_cnt_q + FCW'(1);
         end
`endif
      end
   end

   always_ff @(posedge mclk or posedge clr) begin
      if (clr) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         pixel_x_q     <= '0;
         pixel_y_q     <= '0;
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         vga_on_q      <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
`ifdef VGA_TIMER_FRAME_CNT_EN
         frame_cnt_q   <= '0;
`endif
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         pixel_x_q     <= pixel_x_d;
         pixel_y_q     <= pixel_y_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         vga_on_q      <= vga_on_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
`ifdef VGA_TIMER_FRAME_CNT_EN
         frame_cnt_q   <= frame_cnt_d;
`endif
      end
   end

   assign vif.hsync       = hsync_q;
   assign vif.vsync       = vsync_q;
   assign vif.vga_on      = vga_on_q;
   assign vif.Pixel_X     = pixel_x_q;
   assign vif.Pixel_Y     = pixel_y_q;
   assign vif.line_start  = line_start_q;
   assign vif.frame_start = frame_start_q;
`ifdef VGA_TIMER_FRAME_CNT_EN
   assign vif.frame_cnt   = frame_cnt_q;
`endif

endmodule
